// File: rtl/mux_n_1_pipelined_pkg.sv
// Shared constants and elaboration helpers for the pipelined N:1 mux tree.
// Each tree level is a registered 4:1 select, so lane counts shrink by 4 per level.
package mux_pkg;

  localparam int MAX_N = 256;

  function automatic int pow4(input int k);
    return 1 << (2 * k);
  endfunction

  function automatic int clog4(input int n);
    int k;
    k = 0;
    while (pow4(k) < n) k++;
    return k;
  endfunction

  // Lanes leaving level k: ceil(n / 4^(k+1)).
  function automatic int lanes_out(input int n, input int k);
    return (n + pow4(k + 1) - 1) / pow4(k + 1);
  endfunction

  function automatic int lanes_in(input int n, input int k);
    return (k == 0) ? n : lanes_out(n, k - 1);
  endfunction

endpackage

// File: rtl/mux_n_1_pipelined_if.sv
// Beat-in / beat-out handshake bundle for the pipelined mux.
interface mux_n_1_pipelined_if #(
  parameter int N     = 16,
  parameter int WIDTH = 16
) ();
  localparam int SEL_W = $clog2(N);

  logic [N*WIDTH-1:0] x;
  logic [SEL_W-1:0]   s;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   out;
  logic               out_valid;
  logic               out_ready;
  logic               out_err;

  modport master (output x, s, in_valid, out_ready,
                  input  in_ready, out, out_valid, out_err);
  modport slave  (input  x, s, in_valid, out_ready,
                  output in_ready, out, out_valid, out_err);
endinterface

// File: rtl/mux_n_1_pipelined_stage.sv
// One registered tree level: 4:1 (or 2:1 on the last odd level) select per lane group,
// carrying the unused select bits and error flag alongside the data.
module mux_4_1_stage
  import mux_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int LANES_IN      = 16,
  parameter int SEL_BITS_LEFT = 4
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_valid,
  output logic                                o_ready,
  input  logic [LANES_IN*WIDTH-1:0]           i_data,
  input  logic [SEL_BITS_LEFT-1:0]            i_sel,
  input  logic                                i_err,
  output logic                                o_valid,
  input  logic                                i_ready,
  output logic [((LANES_IN+3)/4)*WIDTH-1:0]   o_data,
  output logic [((SEL_BITS_LEFT > 2) ? SEL_BITS_LEFT-2 : 1)-1:0] o_sel,
  output logic                                o_err
);
  localparam int SB        = (SEL_BITS_LEFT >= 2) ? 2 : 1;
  localparam int SREM      = SEL_BITS_LEFT - SB;
  localparam int SOUT_W    = (SREM > 0) ? SREM : 1;
  localparam int LANES_OUT = (LANES_IN + 3) / 4;

  logic [LANES_OUT*4*WIDTH-1:0] w_pad;
  logic [LANES_OUT*WIDTH-1:0]   w_mux;
  logic [1:0]                   w_idx;
  logic [SOUT_W-1:0]            w_sel_nxt;

  logic                         r_valid;
  logic [LANES_OUT*WIDTH-1:0]   r_data;
  logic [SOUT_W-1:0]            r_sel;
  logic                         r_err;

  if (SB == 2) begin : g_idx4
    assign w_idx = i_sel[1:0];
  end else begin : g_idx2
    assign w_idx = {1'b0, i_sel[0]};
  end

  if (SREM > 0) begin : g_carry
    assign w_sel_nxt = i_sel[SEL_BITS_LEFT-1:SB];
  end else begin : g_nocarry
    assign w_sel_nxt = '0;
  end

  // Missing lanes read as zero so a partial last group still selects cleanly.
  always_comb begin
    w_pad = '0;
    w_pad[LANES_IN*WIDTH-1:0] = i_data;
  end

  always_comb begin
    w_mux = '0;
    for (int g = 0; g < LANES_OUT; g++)
      w_mux[g*WIDTH +: WIDTH] = w_pad[(g*4 + int'(w_idx))*WIDTH +: WIDTH];
    if (i_err) w_mux = '0;
  end

  assign o_ready = !r_valid || i_ready;

  // Payload only moves with a real beat, so a stalled or idle output stays bit-stable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_err   <= 1'b0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= w_mux;
        r_sel  <= w_sel_nxt;
        r_err  <= i_err;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_sel   = r_sel;
  assign o_err   = r_err;
endmodule

// File: rtl/mux_n_1_pipelined.sv
// N:1 mux as a chain of registered 4:1 levels with valid/ready backpressure and
// out-of-range select flagging; output is driven straight from the last level's registers.
module mux_n_1_pipelined
  import mux_pkg::*;
#(
  parameter int N     = 16,
  parameter int WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  mux_n_1_pipelined_if.slave     bus
);
  localparam int SEL_W  = $clog2(N);
  localparam int LEVELS = (SEL_W + 1) / 2;
  localparam logic [SEL_W:0] N_L = (SEL_W+1)'(N);

  logic [LEVELS:0] w_valid;
  logic [LEVELS:0] w_ready;
  logic [LEVELS:0] w_err;

  assign w_valid[0]      = bus.in_valid;
  assign w_err[0]        = ({1'b0, bus.s} >= N_L);
  assign w_ready[LEVELS] = bus.out_ready;
  // Held low during reset even though the empty pipe would otherwise report ready.
  assign bus.in_ready    = i_rst_n & w_ready[0];

  for (genvar k = 0; k < LEVELS; k++) begin : gen_lvl
    localparam int LIN  = lanes_in(N, k);
    localparam int LOUT = lanes_out(N, k);
    localparam int SBL  = SEL_W - 2 * k;
    localparam int SOW  = (SBL > 2) ? SBL - 2 : 1;

    logic [LIN*WIDTH-1:0]  w_di;
    logic [SBL-1:0]        w_si;
    logic [LOUT*WIDTH-1:0] w_d;
    logic [SOW-1:0]        w_s;

    if (k == 0) begin : g_first
      assign w_di = bus.x;
      assign w_si = bus.s;
    end else begin : g_next
      assign w_di = gen_lvl[k-1].w_d;
      assign w_si = gen_lvl[k-1].w_s;
    end

    mux_4_1_stage #(
      .WIDTH        (WIDTH),
      .LANES_IN     (LIN),
      .SEL_BITS_LEFT(SBL)
    ) u_stage (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_valid(w_valid[k]),
      .o_ready(w_ready[k]),
      .i_data (w_di),
      .i_sel  (w_si),
      .i_err  (w_err[k]),
      .o_valid(w_valid[k+1]),
      .i_ready(w_ready[k+1]),
      .o_data (w_d),
      .o_sel  (w_s),
      .o_err  (w_err[k+1])
    );
  end

  assign bus.out       = gen_lvl[LEVELS-1].w_d;
  assign bus.out_valid = w_valid[LEVELS];
  assign bus.out_err   = w_err[LEVELS];
endmodule

// File: tb/tb_mux_n_1_pipelined.sv
// Scoreboarded bench: three configurations (16x16, 10x16, 64x8) driven with directed beats.
module tb_mux_n_1_pipelined;
  typedef struct {
    logic [15:0] d;
    logic        e;
    int          acc;
    bit          chk;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   lat_chk = 1'b1;
  exp_t qa[$], qb[$], qc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mux_n_1_pipelined_if #(.N(16), .WIDTH(16)) ia ();
  mux_n_1_pipelined_if #(.N(10), .WIDTH(16)) ib ();
  mux_n_1_pipelined_if #(.N(64), .WIDTH(8))  ic ();

  mux_n_1_pipelined #(.N(16), .WIDTH(16)) dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(ia));
  mux_n_1_pipelined #(.N(10), .WIDTH(16)) dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(ib));
  mux_n_1_pipelined #(.N(64), .WIDTH(8))  dut_c (.i_clk(clk), .i_rst_n(rst_n), .bus(ic));

  localparam int LAT [3] = '{2, 2, 3};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic send(input int dut, input logic [7:0] s, input logic [15:0] d, input logic e);
    exp_t ex;
    logic rdy;
    int   tries;
    rdy = 1'b0;
    tries = 0;
    case (dut)
      0: begin ia.s = s[3:0]; ia.in_valid = 1'b1; end
      1: begin ib.s = s[3:0]; ib.in_valid = 1'b1; end
      default: begin ic.s = s[5:0]; ic.in_valid = 1'b1; end
    endcase
    while (!rdy && tries < 50) begin
      @(negedge clk);
      rdy = (dut == 0) ? ia.in_ready : (dut == 1) ? ib.in_ready : ic.in_ready;
      if (rdy) begin
        ex.d = d; ex.e = e; ex.acc = cyc; ex.chk = lat_chk;
        case (dut)
          0: qa.push_back(ex);
          1: qb.push_back(ex);
          default: qc.push_back(ex);
        endcase
      end
      @(posedge clk); #1;
      tries++;
    end
    if (!rdy) check("accept_timeout", 32'd0, 32'd1);
    ia.in_valid = 1'b0; ib.in_valid = 1'b0; ic.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (qa.size() == 0 && qb.size() == 0 && qc.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain_a", qa.size(), 0);
    check("drain_b", qb.size(), 0);
    check("drain_c", qc.size(), 0);
  endtask

  // Monitor: pops on every delivered output, and checks hold during stalls.
  bit          stall [3];
  logic [15:0] hold_d [3];
  logic        hold_e [3];
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        logic        v, r, e, got;
        logic [15:0] o;
        exp_t        ex;
        case (d)
          0: begin v = ia.out_valid; r = ia.out_ready; o = ia.out; e = ia.out_err; end
          1: begin v = ib.out_valid; r = ib.out_ready; o = ib.out; e = ib.out_err; end
          default: begin v = ic.out_valid; r = ic.out_ready; o = {8'h00, ic.out}; e = ic.out_err; end
        endcase
        if (stall[d]) begin
          check("stall_hold_data", {16'h0, o}, {16'h0, hold_d[d]});
          check("stall_hold_err", {31'h0, e}, {31'h0, hold_e[d]});
        end
        stall[d] = v && !r;
        hold_d[d] = o;
        hold_e[d] = e;
        if (v && r) begin
          got = 1'b0;
          case (d)
            0: if (qa.size() > 0) begin ex = qa.pop_front(); got = 1'b1; end
            1: if (qb.size() > 0) begin ex = qb.pop_front(); got = 1'b1; end
            default: if (qc.size() > 0) begin ex = qc.pop_front(); got = 1'b1; end
          endcase
          if (!got) begin
            check("unexpected_output", {16'h0, o}, 32'hFFFF_FFFF);
          end else begin
            check("out_data", {16'h0, o}, {16'h0, ex.d});
            check("out_err", {31'h0, e}, {31'h0, ex.e});
            if (ex.chk) check("latency", cyc - ex.acc, LAT[d]);
          end
        end
      end
    end
  end

  localparam logic [7:0]  B_S [6] = '{8'd9, 8'd12, 8'd0, 8'd10, 8'd15, 8'd4};
  localparam logic [15:0] B_D [6] = '{16'h2009, 16'h0000, 16'h2000, 16'h0000, 16'h0000, 16'h2004};
  localparam logic        B_E [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    for (int i = 0; i < 16; i++) ia.x[i*16 +: 16] = 16'h1000 + 16'(i);
    for (int i = 0; i < 10; i++) ib.x[i*16 +: 16] = 16'h2000 + 16'(i);
    for (int i = 0; i < 64; i++) ic.x[i*8 +: 8] = 8'(i);
    ia.s = '0; ib.s = '0; ic.s = '0;
    ia.in_valid = 1'b0; ib.in_valid = 1'b0; ic.in_valid = 1'b0;
    ia.out_ready = 1'b1; ib.out_ready = 1'b1; ic.out_ready = 1'b1;

    #2;
    check("rst_out_valid", {29'h0, ia.out_valid, ib.out_valid, ic.out_valid}, 0);
    check("rst_out", {ia.out, ic.out, 8'h00}, 0);
    check("rst_out_err", {29'h0, ia.out_err, ib.out_err, ic.out_err}, 0);
    check("rst_in_ready", {29'h0, ia.in_ready, ib.in_ready, ic.in_ready}, 0);
    #20 rst_n = 1'b1;
    #1 check("post_rst_in_ready", {29'h0, ia.in_ready, ib.in_ready, ic.in_ready}, 32'h7);
    @(posedge clk); #1;

    // Streaming sweep
    lat_chk = 1'b1;
    for (int s = 0; s < 16; s++) send(0, 8'(s), 16'h1000 + 16'(s), 1'b0);
    drain();

    // Backpressure: stall three cycles while 16'h1003 is presented
    lat_chk = 1'b0;
    fork
      for (int s = 0; s < 16; s++) send(0, 8'(s), 16'h1000 + 16'(s), 1'b0);
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
          @(posedge clk); #1;
          seen = ia.out_valid && ia.out == 16'h1003;
        end
        check("bp_saw_1003", {31'h0, seen}, 1);
        ia.out_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        check("bp_in_ready_low", {31'h0, ia.in_ready}, 0);
        repeat (2) @(posedge clk);
        #1 ia.out_ready = 1'b1;
      end
    join
    drain();

    // Out-of-range on N=10
    lat_chk = 1'b1;
    for (int i = 0; i < 6; i++) send(1, B_S[i], B_D[i], B_E[i]);
    drain();

    // Bubbles
    send(0, 8'd5, 16'h1005, 1'b0);
    @(posedge clk); #1;
    send(0, 8'd7, 16'h1007, 1'b0);
    @(posedge clk); #1;
    drain();

    // Deep configuration
    send(2, 8'd63, 16'h003F, 1'b0);
    send(2, 8'd0,  16'h0000, 1'b0);
    send(2, 8'd21, 16'h0015, 1'b0);
    send(2, 8'd42, 16'h002A, 1'b0);
    drain();

    // Async reset with two beats in flight
    send(0, 8'd0, 16'h1000, 1'b0);
    send(0, 8'd1, 16'h1001, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'h0, ia.out_valid}, 0);
    check("midrst_out", {16'h0, ia.out}, 0);
    check("midrst_in_ready", {31'h0, ia.in_ready}, 0);
    qa.delete(); qb.delete(); qc.delete();
    @(posedge clk); #2 rst_n = 1'b1;
    #1 check("rerst_in_ready", {31'h0, ia.in_ready}, 1);
    send(0, 8'd3, 16'h1003, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_n_1_pipelined.md
Name: mux_n_1_pipelined

Overview:
- Parametrised N:1 multiplexer, WIDTH bits per input, built as a tree of registered 4:1 stages.
- Successor to the fixed 16:1 × 16-bit combinational mux. Adds:
  - generic input count and width;
  - one pipeline register per tree level;
  - valid/ready flow control with backpressure;
  - out-of-range select detection.
- Sits between the register-file/ALU result buses and the datapath write-back, where the combinational tree limited timing.

Parameters:
- WIDTH, 16, bits per input lane and on OUT.
- N, 16, number of inputs; legal range 2..256.
- SEL_W, $clog2(N), select width (derived; do not override).
- LEVELS, ceil(SEL_W/2), number of registered 4:1 tree levels (derived).

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- X  in  N*WIDTH  flat input bus; lane i = X[i*WIDTH +: WIDTH].
- S  in  SEL_W  lane select, sampled with the input beat.
- IN_VALID  in  1  input beat valid.
- IN_READY  out  1  block accepts a beat this cycle.
- OUT  out  WIDTH  selected data.
- OUT_VALID  out  1  OUT/OUT_ERR valid.
- OUT_READY  in  1  downstream accepts the output.
- OUT_ERR  out  1  beat had S >= N.

Behaviour:
- Reset:
  - Single clock, CLK. RST_N is asynchronous, active-low.
  - While RST_N is low: all stage valids = 0, all data/select/err registers = 0, OUT = 0, OUT_VALID = 0, OUT_ERR = 0, IN_READY = 0.
  - After release, IN_READY = 1 on the first cycle.
- Input beat: accepted on a rising edge with IN_VALID && IN_READY.
- Level 0:
  - Split lanes into groups of 4; missing lanes (N not a multiple of 4^k) are zero-padded.
  - Selects within each group using S[1:0].
  - Registers ceil(N/4) results, plus S[SEL_W-1:2], the err bit and valid.
- Level k (1..LEVELS-1):
  - Selects with the next 2 select bits; registers ceil(N/4^(k+1)) results.
  - The final level holds one result, driving OUT, OUT_ERR and OUT_VALID directly from registers.
  - For odd SEL_W, the final level uses 1 select bit (2:1).
- Error flag: err = (S >= N), computed at level 0. An errored beat must produce OUT = 0 and OUT_ERR = 1, and is still delivered with OUT_VALID.
- Latency and throughput:
  - Latency = LEVELS cycles from accept edge to OUT_VALID (N=16: 2; N=64: 3; N=4: 1).
  - Throughput: 1 beat/cycle while OUT_READY = 1.
- Flow control:
  - ready_k = !valid_k || ready_{k+1}; ready_LEVELS = OUT_READY; IN_READY = ready_0.
  - A combinational ready path is permitted.
  - Stage k loads when ready_k. It loads valid = 0 if the upstream stage has no valid beat (bubble).
- Stall:
  - While OUT_VALID && !OUT_READY, OUT and OUT_ERR hold bit-stable.
  - Internal bubbles still collapse: empty stages fill.
  - IN_READY drops only when every level holds a valid beat.
- Ordering: no beat is dropped, duplicated or reordered.
- Input isolation: X/S changes after accept do not affect in-flight beats. X/S are don't-care when IN_VALID = 0.
- Reset mid-operation: all in-flight beats are discarded immediately (async). The first output after release is the first beat accepted after release.
- Simultaneous accept and drain at a full pipe: when OUT_READY = 1 and all levels are full, IN_READY = 1 and the pipe shifts in one cycle with no bubble.

Decomposition:
- Package mux_pkg:
  - function clog4(n);
  - MAX_N = 256 constant;
  - localparam helpers for per-level lane count ceil(N/4^(k+1)).
- Sub-module mux_4_1_stage (parameters WIDTH, LANES_IN, SEL_BITS_LEFT):
  - one registered level containing the 4:1 select, valid/ready logic, and select/err carry registers.
  - Top instantiates LEVELS copies in a generate loop.

Test Plan:
- Streaming sweep (N=16, WIDTH=16, X lane i = 16'h1000+i, OUT_READY=1): S = 0..15 back-to-back -> OUT_VALID first high 2 cycles after the first accept; OUT = 16'h1000..16'h100F, one per cycle; OUT_ERR = 0.
- Backpressure: same stream, OUT_READY low for 3 cycles starting at 4th output (16'h1003) -> OUT held at 16'h1003; IN_READY low once both levels are full; after release, the sequence continues 16'h1004.. with no loss or duplicate.
- Out-of-range (N=10, WIDTH=16): S=9 -> OUT = X9, OUT_ERR=0; S=12 -> OUT=16'h0000, OUT_ERR=1, OUT_VALID=1.
- Bubbles: IN_VALID alternating 1/0 with S=5 and S=7 -> OUT_VALID alternates with 2-cycle latency; OUT = X5 then X7.
- Async reset mid-stream: drop RST_N between clock edges with 2 beats in flight -> OUT_VALID=0, OUT=0 before the next edge; after release, a beat with S=3 yields X3 after 2 cycles and no stale beats appear.
- Deep configuration (N=64, WIDTH=8, X lane i = i): S=63 -> OUT = 8'h3F after 3 cycles; S=0 -> 8'h00.
